idu_hazard_ctrl: RTL and testbench

- Issue-stage scheduler that sits beside the IDU.
- It holds the IDU→EXU handshake on load-use register hazards, using a per-register load scoreboard.
- It sequences FENCE.I: drain, then I-cache invalidate, then pipeline flush.
- It drives the front-end flush on BRU redirects. Its outputs feed the IDU's post-ready gating and the IFU/IDU flush inputs.

---
 rtl/idu_hazard_ctrl_if.sv | 60 ++++++
 rtl/idu_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_idu_hazard_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/idu_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// idu_hazard_ctrl_if
//   Signal bundle between the issue-stage neighbours (IDU, EXU, LSU, BRU,
//   I-cache) and the hazard/fence controller.
//
//   master : the pipeline side; drives the i_* signals, observes the o_* ones
//   slave  : the controller; observes the i_* signals, drives the o_* ones
//
//   i_idu_valid/i_exu_ready/i_idu_nop  IDU->EXU handshake view
//   i_idu_rs1id/rs2id/rdid/rdwen       register usage of the IDU instruction
//   i_idu_lden/i_idu_fencei            instruction class
//   i_lsu_ldok/i_lsu_ldrdid            load writeback
//   i_lsu_stidle                       store buffer empty
//   i_bru_redirect                     BRU redirect
//   i_ic_inv_done                      I-cache invalidate done pulse
//   o_idu_hold/o_flush/o_ic_inv        control back to the pipeline
//   o_fence_busy/o_ld_cnt              status
// ---------------------------------------------------------------------------
interface idu_hazard_ctrl_if #(
  parameter int REG_ADDRW = 5,
  parameter int CNTW      = 3
);
  logic                 i_idu_valid;
  logic                 i_exu_ready;
  logic                 i_idu_nop;
  logic [REG_ADDRW-1:0] i_idu_rs1id;
  logic [REG_ADDRW-1:0] i_idu_rs2id;
  logic [REG_ADDRW-1:0] i_idu_rdid;
  logic                 i_idu_rdwen;
  logic                 i_idu_lden;
  logic                 i_idu_fencei;
  logic                 i_lsu_ldok;
  logic [REG_ADDRW-1:0] i_lsu_ldrdid;
  logic                 i_lsu_stidle;
  logic                 i_bru_redirect;
  logic                 i_ic_inv_done;
  logic                 o_idu_hold;
  logic                 o_flush;
  logic                 o_ic_inv;
  logic                 o_fence_busy;
  logic [CNTW-1:0]      o_ld_cnt;

  modport master (
    output i_idu_valid, i_exu_ready, i_idu_nop,
    output i_idu_rs1id, i_idu_rs2id, i_idu_rdid, i_idu_rdwen,
    output i_idu_lden, i_idu_fencei,
    output i_lsu_ldok, i_lsu_ldrdid, i_lsu_stidle,
    output i_bru_redirect, i_ic_inv_done,
    input  o_idu_hold, o_flush, o_ic_inv, o_fence_busy, o_ld_cnt
  );

  modport slave (
    input  i_idu_valid, i_exu_ready, i_idu_nop,
    input  i_idu_rs1id, i_idu_rs2id, i_idu_rdid, i_idu_rdwen,
    input  i_idu_lden, i_idu_fencei,
    input  i_lsu_ldok, i_lsu_ldrdid, i_lsu_stidle,
    input  i_bru_redirect, i_ic_inv_done,
    output o_idu_hold, o_flush, o_ic_inv, o_fence_busy, o_ld_cnt
  );
endinterface

// File: rtl/idu_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// idu_hazard_ctrl
//   Issue-stage scheduler beside the IDU. Holds the IDU->EXU handshake on
//   load-use and write-after-write hazards using a per-register load
//   scoreboard, limits outstanding loads, sequences FENCE.I (drain, I-cache
//   invalidate, flush) and forwards BRU redirects as a front-end flush.
//
//   Ports
//     i_clk   clock
//     i_rst   synchronous reset, active-high
//     hz_if   idu_hazard_ctrl_if.slave bundle (see interface header)
//
//   CNTW must satisfy 2**CNTW > MAX_LD.
//
//   FSM states
//     state      | meaning
//     S_IDLE     | normal issue; a FENCE.I in IDU is held and starts a sequence
//     S_DRAIN    | wait for outstanding loads and the store buffer to empty
//     S_INV      | I-cache invalidate requested, wait for done pulse
//     S_RELEASE  | one-cycle front-end flush; fence released to issue as nop
// ---------------------------------------------------------------------------
module idu_hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int REG_ADDRW = 5,
  parameter int MAX_LD    = 4,
  parameter int CNTW      = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  idu_hazard_ctrl_if.slave hz_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_INV     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_nxt;
  logic [NREG-1:0] sb_clr;
  logic [NREG-1:0] sb_set;
  logic [NREG-1:0] sb_byp;

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;

  logic            rs1_hz;
  logic            rs2_hz;
  logic            hz;
  logic            waw;
  logic            cnt_full;
  logic            cnt_lim;
  logic            fsm_hold;
  logic            hold;
  logic            fire;
  logic            ld_inc;

  // ------------------------------------------------------------------
  // Scoreboard masks
  // ------------------------------------------------------------------
  always_comb begin
    sb_clr = '0;
    if (hz_if.i_lsu_ldok) begin
      sb_clr[hz_if.i_lsu_ldrdid] = 1'b1;
    end
  end

  // A load writing back this cycle no longer blocks its consumers.
  assign sb_byp = sb & ~sb_clr;

  assign rs1_hz = sb_byp[hz_if.i_idu_rs1id] && (hz_if.i_idu_rs1id != '0);
  assign rs2_hz = sb_byp[hz_if.i_idu_rs2id] && (hz_if.i_idu_rs2id != '0);
  assign hz     = hz_if.i_idu_valid && (rs1_hz || rs2_hz);

  // WAW looks at the unbypassed scoreboard, so a set and a clear of the
  // same register can never land on the same edge.
  assign waw = hz_if.i_idu_valid && hz_if.i_idu_rdwen &&
               (hz_if.i_idu_rdid != '0) && sb[hz_if.i_idu_rdid];

  // A completing load frees a slot in the same cycle.
  assign cnt_full = (cnt == CNTW'(MAX_LD));
  assign cnt_lim  = hz_if.i_idu_valid && hz_if.i_idu_lden &&
                    cnt_full && !hz_if.i_lsu_ldok;

  // RELEASE intentionally does not hold: that is the cycle the fence leaves.
  assign fsm_hold = (state == S_DRAIN) || (state == S_INV) ||
                    (hz_if.i_idu_valid && hz_if.i_idu_fencei && (state == S_IDLE));

  assign hold   = hz || waw || cnt_lim || fsm_hold;
  assign fire   = hz_if.i_idu_valid && hz_if.i_exu_ready && !hold && !hz_if.i_idu_nop;
  assign ld_inc = fire && hz_if.i_idu_lden;

  always_comb begin
    sb_set = '0;
    if (ld_inc && hz_if.i_idu_rdwen && (hz_if.i_idu_rdid != '0)) begin
      sb_set[hz_if.i_idu_rdid] = 1'b1;
    end
  end

  assign sb_nxt = (sb & ~sb_clr) | sb_set;

  // ------------------------------------------------------------------
  // Outstanding-load counter, saturating at zero
  // ------------------------------------------------------------------
  always_comb begin
    cnt_nxt = cnt;
    if (ld_inc && !hz_if.i_lsu_ldok) begin
      cnt_nxt = cnt + 1'b1;
    end else if (!ld_inc && hz_if.i_lsu_ldok && (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sb  <= '0;
      cnt <= '0;
    end else begin
      sb  <= sb_nxt;
      cnt <= cnt_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FENCE.I sequencer
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // A redirect in the same cycle kills the fence in IDU.
        if (hz_if.i_idu_valid && hz_if.i_idu_fencei && !hz_if.i_bru_redirect) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt == '0) && hz_if.i_lsu_stidle) begin
          state_nxt = S_INV;
        end
      end
      S_INV: begin
        if (hz_if.i_ic_inv_done) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign hz_if.o_idu_hold   = hold;
  assign hz_if.o_flush      = hz_if.i_bru_redirect || (state == S_RELEASE);
  assign hz_if.o_ic_inv     = (state == S_INV);
  assign hz_if.o_fence_busy = (state != S_IDLE);
  assign hz_if.o_ld_cnt     = cnt;

`ifndef SYNTHESIS
  // Load writeback with nothing outstanding is an LSU protocol violation.
  a_no_ldok_underflow : assert property (
    @(posedge i_clk) disable iff (i_rst)
    hz_if.i_lsu_ldok |-> (cnt != '0)
  );
`endif

endmodule

// File: tb/tb_idu_hazard_ctrl.sv
module tb_idu_hazard_ctrl;

  logic clk;
  logic rst;

  idu_hazard_ctrl_if #(.REG_ADDRW(5), .CNTW(3)) bus ();

  idu_hazard_ctrl #(
    .NREG(32), .REG_ADDRW(5), .MAX_LD(4), .CNTW(3)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .hz_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       hold;
    logic       flush;
    logic       inv;
    logic       busy;
    logic [2:0] cnt;
  } exp_t;

  exp_t q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  task automatic set_idle();
    rst                = 1'b0;
    bus.i_idu_valid    = 1'b0;
    bus.i_exu_ready    = 1'b1;
    bus.i_idu_nop      = 1'b0;
    bus.i_idu_rs1id    = '0;
    bus.i_idu_rs2id    = '0;
    bus.i_idu_rdid     = '0;
    bus.i_idu_rdwen    = 1'b0;
    bus.i_idu_lden     = 1'b0;
    bus.i_idu_fencei   = 1'b0;
    bus.i_lsu_ldok     = 1'b0;
    bus.i_lsu_ldrdid   = '0;
    bus.i_lsu_stidle   = 1'b1;
    bus.i_bru_redirect = 1'b0;
    bus.i_ic_inv_done  = 1'b0;
  endtask

  // Advance one cycle and return inputs to the quiet default.
  task automatic cyc();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic ld(input logic [4:0] rd, input logic [4:0] rs1);
    bus.i_idu_valid = 1'b1;
    bus.i_idu_lden  = 1'b1;
    bus.i_idu_rdwen = 1'b1;
    bus.i_idu_rdid  = rd;
    bus.i_idu_rs1id = rs1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.i_idu_valid = 1'b1;
    bus.i_idu_rdwen = 1'b1;
    bus.i_idu_rdid  = rd;
    bus.i_idu_rs1id = rs1;
    bus.i_idu_rs2id = rs2;
  endtask

  task automatic fence();
    bus.i_idu_valid  = 1'b1;
    bus.i_idu_fencei = 1'b1;
  endtask

  task automatic ldok(input logic [4:0] rd);
    bus.i_lsu_ldok   = 1'b1;
    bus.i_lsu_ldrdid = rd;
  endtask

  task automatic ex(input string n, input logic h, input logic f, input logic i,
                    input logic b, input logic [2:0] c);
    exp_t e;
    e.name  = n;
    e.hold  = h;
    e.flush = f;
    e.inv   = i;
    e.busy  = b;
    e.cnt   = c;
    q.push_back(e);
  endtask

  // Monitor: compares mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors_applied++;
        if ({bus.o_idu_hold, bus.o_flush, bus.o_ic_inv, bus.o_fence_busy, bus.o_ld_cnt} !==
            {e.hold, e.flush, e.inv, e.busy, e.cnt}) begin
          miscompares++;
          $display("FAIL %s: got hold=%0b flush=%0b inv=%0b busy=%0b cnt=%0d, want hold=%0b flush=%0b inv=%0b busy=%0b cnt=%0d",
                   e.name, bus.o_idu_hold, bus.o_flush, bus.o_ic_inv, bus.o_fence_busy, bus.o_ld_cnt,
                   e.hold, e.flush, e.inv, e.busy, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    rst = 1'b1;

    // Reset
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b1;                 ex("reset",        0,0,0,0,0);
    cyc();                             ex("post_reset",   0,0,0,0,0);

    // Load-use with writeback bypass
    cyc(); ld(5, 1);                   ex("lu_ld_fire",   0,0,0,0,0);
    cyc(); alu(6, 5, 1);               ex("lu_hold_1",    1,0,0,0,1);
    cyc(); alu(6, 5, 1);               ex("lu_hold_2",    1,0,0,0,1);
    cyc(); alu(6, 5, 1); ldok(5);      ex("lu_bypass",    0,0,0,0,1);
    cyc(); alu(7, 5, 5);               ex("lu_sb_clear",  0,0,0,0,0);
    cyc();                             ex("lu_idle",      0,0,0,0,0);

    // x0 destination / sources
    cyc(); ld(0, 2);                   ex("x0_ld",        0,0,0,0,0);
    cyc(); alu(1, 0, 0);               ex("x0_src",       0,0,0,0,1);
    cyc();                             ex("x0_cnt",       0,0,0,0,1);
    cyc(); ldok(0);                    ex("x0_ldok",      0,0,0,0,1);
    cyc();                             ex("x0_done",      0,0,0,0,0);

    // Outstanding-load limit
    for (int i = 1; i <= 4; i++) begin
      cyc(); ld(5'(i), 0);             ex("lim_fill",     0,0,0,0,3'(i-1));
    end
    cyc(); ld(8, 0);                   ex("lim_hold_1",   1,0,0,0,4);
    cyc(); ld(8, 0);                   ex("lim_hold_2",   1,0,0,0,4);
    cyc(); ld(8, 0); ldok(1);          ex("lim_release",  0,0,0,0,4);
    cyc();                             ex("lim_cnt_keep", 0,0,0,0,4);
    cyc(); ldok(2);                    ex("lim_drain",    0,0,0,0,4);
    cyc(); ldok(3);                    ex("lim_drain",    0,0,0,0,3);
    cyc(); ldok(4);                    ex("lim_drain",    0,0,0,0,2);
    cyc(); ldok(8);                    ex("lim_drain",    0,0,0,0,1);
    cyc();                             ex("lim_empty",    0,0,0,0,0);

    // Write-after-write
    cyc(); ld(7, 0);                   ex("waw_first",    0,0,0,0,0);
    cyc(); ld(7, 0);                   ex("waw_hold",     1,0,0,0,1);
    cyc(); ld(7, 0); ldok(7);          ex("waw_hold_ok",  1,0,0,0,1);
    cyc(); ld(7, 0);                   ex("waw_issue",    0,0,0,0,0);
    cyc(); alu(9, 7, 0);               ex("waw_sb_set",   1,0,0,0,1);
    cyc(); alu(9, 7, 0); ldok(7);      ex("waw_bypass",   0,0,0,0,1);
    cyc();                             ex("waw_done",     0,0,0,0,0);

    // FENCE.I sequence
    cyc(); ld(10, 0);                  ex("fi_ld_a",      0,0,0,0,0);
    cyc(); ld(11, 0);                  ex("fi_ld_b",      0,0,0,0,1);
    cyc(); fence(); bus.i_lsu_stidle = 1'b0;
                                       ex("fi_enter",     1,0,0,0,2);
    cyc(); fence(); bus.i_lsu_stidle = 1'b0; ldok(10);
                                       ex("fi_drain_1",   1,0,0,1,2);
    cyc(); fence(); bus.i_lsu_stidle = 1'b0; ldok(11);
                                       ex("fi_drain_2",   1,0,0,1,1);
    cyc(); fence(); bus.i_lsu_stidle = 1'b0;
                                       ex("fi_drain_st",  1,0,0,1,0);
    cyc(); fence();                    ex("fi_drain_end", 1,0,0,1,0);
    cyc(); fence();                    ex("fi_inv_1",     1,0,1,1,0);
    cyc(); fence();                    ex("fi_inv_2",     1,0,1,1,0);
    cyc(); fence(); bus.i_ic_inv_done = 1'b1;
                                       ex("fi_inv_done",  1,0,1,1,0);
    cyc(); fence(); bus.i_idu_nop = 1'b1;
                                       ex("fi_release",   0,1,0,1,0);
    cyc();                             ex("fi_idle",      0,0,0,0,0);

    // Redirect keeps the scoreboard
    cyc(); ld(12, 0);                  ex("rd_ld",        0,0,0,0,0);
    cyc(); bus.i_bru_redirect = 1'b1;  ex("rd_flush",     0,1,0,0,1);
    cyc(); alu(13, 12, 0);             ex("rd_sb_kept",   1,0,0,0,1);
    cyc(); ldok(12);                   ex("rd_ldok",      0,0,0,0,1);
    cyc();                             ex("rd_done",      0,0,0,0,0);

    // Reset during invalidate
    cyc(); fence();                    ex("rs_enter",     1,0,0,0,0);
    cyc(); fence();                    ex("rs_drain",     1,0,0,1,0);
    cyc(); fence();                    ex("rs_inv",       1,0,1,1,0);
    cyc(); rst = 1'b1;                 ex("rs_assert",    1,0,1,1,0);
    cyc();                             ex("rs_after",     0,0,0,0,0);

    // Reset with a load outstanding clears scoreboard and count
    cyc(); ld(14, 0);                  ex("rs_ld",        0,0,0,0,0);
    cyc(); rst = 1'b1;                 ex("rs_ld_pend",   0,0,0,0,1);
    cyc(); alu(15, 14, 0);             ex("rs_sb_clear",  0,0,0,0,0);
    cyc();

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
